// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: state encoding, width
// defaults and the round-robin pointer wrap helper.
package mem_port_arb_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = IDLE,
        ST_ISSUE     = ISSUE,
        ST_WAIT_RESP = WAIT_RESP
    } arb_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Next requester index after idx, wrapping from n-1 back to 0.
    function automatic int ptr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side handshake bundle of the memory port arbiter.
// Optional macro MEM_PORT_ARBITER_LOCK_EN adds the per-requester lock input.
interface mem_port_arbiter_if
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0]        resp_valid_o;
    logic [NUM_REQ-1:0]        resp_ready_i;
    logic [DATA_W-1:0]         resp_data_o;
    logic [IDX_W-1:0]          grant_id_o;
    logic                      busy_o;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic                      mem_resp_valid_i;
    logic                      mem_resp_ready_o;
    logic [DATA_W-1:0]         mem_data_i;
`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock_i;
`endif

    // Arbiter side.
    modport master (
        input  req_valid_i, req_addr_i, resp_ready_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_data_i,
`ifdef MEM_PORT_ARBITER_LOCK_EN
        input  req_lock_i,
`endif
        output req_ready_o, resp_valid_o, resp_data_o, grant_id_o, busy_o,
        output mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

    // Requesters plus memory, seen from outside the arbiter.
    modport slave (
        output req_valid_i, req_addr_i, resp_ready_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_data_i,
`ifdef MEM_PORT_ARBITER_LOCK_EN
        output req_lock_i,
`endif
        input  req_ready_o, resp_valid_o, resp_data_o, grant_id_o, busy_o,
        input  mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr with wrap. Returns a one-hot grant, its index and an any-request flag.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Rotating priority scan; the first hit from ptr wins.
    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any && req[k[IDX_W-1:0]]) begin
                any                = 1'b1;
                gnt[k[IDX_W-1:0]]  = 1'b1;
                idx                = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters with a
// single outstanding transaction. Optional macro MEM_PORT_ARBITER_LOCK_EN lets
// the last granted requester keep the port across back-to-back accesses.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [NUM_REQ-1:0]  win_gnt;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  grant_oh;
    logic                resp_hs;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req (bus.req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant_oh = NUM_REQ'(1) << grant_q;

`ifdef MEM_PORT_ARBITER_LOCK_EN
    logic lock_q;
    logic lock_hit;

    // A held lock overrides the rotation whenever the owner is requesting.
    assign lock_hit = lock_q & bus.req_valid_i[grant_q];
    assign win_gnt  = lock_hit ? grant_oh : pick_gnt;
    assign win_idx  = lock_hit ? grant_q  : pick_idx;
`else
    assign win_gnt  = pick_gnt;
    assign win_idx  = pick_idx;
`endif

    assign resp_hs = (state == ST_WAIT_RESP) & bus.mem_resp_valid_i & bus.resp_ready_i[grant_q];

    // Arbitration, address capture and transaction sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
`ifdef MEM_PORT_ARBITER_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        addr_q  <= bus.req_addr_i[win_idx*ADDR_W +: ADDR_W];
                        grant_q <= win_idx;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_req_ready_i) state <= ST_WAIT_RESP;
                end
                ST_WAIT_RESP: begin
                    if (resp_hs) begin
                        state <= ST_IDLE;
`ifdef MEM_PORT_ARBITER_LOCK_EN
                        lock_q <= bus.req_lock_i[grant_q];
                        if (!bus.req_lock_i[grant_q])
                            rr_ptr <= IDX_W'(ptr_wrap(int'(grant_q), NUM_REQ));
`else
                        rr_ptr <= IDX_W'(ptr_wrap(int'(grant_q), NUM_REQ));
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request acceptance is blocked while reset is held so every handshake
    // output reads zero during reset, not only after the first edge.
    assign bus.req_ready_o      = (rst_n && state == ST_IDLE && pick_any) ? win_gnt : '0;
    assign bus.mem_req_valid_o  = (state == ST_ISSUE);
    assign bus.mem_addr_o       = (state != ST_IDLE) ? addr_q : '0;
    assign bus.resp_valid_o     = (state == ST_WAIT_RESP && bus.mem_resp_valid_i) ? grant_oh : '0;
    assign bus.resp_data_o      = (state == ST_WAIT_RESP) ? bus.mem_data_i : '0;
    assign bus.mem_resp_ready_o = (state == ST_WAIT_RESP) & bus.resp_ready_i[grant_q];
    assign bus.grant_id_o       = grant_q;
    assign bus.busy_o           = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three requesters.
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [95:0] addrs;
        int          exp_g;
        logic [31:0] exp_addr;
        logic [31:0] data;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_lock(input logic [2:0] l);
`ifdef MEM_PORT_ARBITER_LOCK_EN
        bus.req_lock_i = l;
`else
        if (l != 3'b000) begin end
`endif
    endtask

    // One full transaction; entered and left at posedge+1 in IDLE.
    task automatic do_txn(input logic [2:0] valid, input logic [95:0] addrs, input int exp_g,
                          input logic [31:0] exp_addr, input logic [31:0] data, input int lat);
        logic [2:0] oh;
        oh = 3'(1 << exp_g);
        bus.req_valid_i = valid;
        bus.req_addr_i  = addrs;
        #1;
        chk("req_ready_idle", 64'(bus.req_ready_o), 64'(oh));
        chk("busy_idle", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        for (int c = 0; c < lat; c++) begin
            bus.mem_req_ready_i = 1'b0;
            chk("mem_req_valid_stall", 64'(bus.mem_req_valid_o), 64'd1);
            chk("mem_addr_stall", 64'(bus.mem_addr_o), 64'(exp_addr));
            @(posedge clk); #1;
        end
        bus.mem_req_ready_i = 1'b1;
        chk("mem_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
        chk("mem_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
        chk("grant_id", 64'(bus.grant_id_o), 64'(exp_g));
        chk("req_ready_issue", 64'(bus.req_ready_o), 64'd0);
        @(posedge clk); #1;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_data_i       = data;
        bus.resp_ready_i     = 3'b111;
        #1;
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(oh));
        chk("resp_data", 64'(bus.resp_data_o), 64'(data));
        chk("mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd1);
        chk("req_ready_wait", 64'(bus.req_ready_o), 64'd0);
        @(posedge clk); #1;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_data_i       = '0;
        chk("busy_after", 64'(bus.busy_o), 64'd0);
    endtask

    vec_t vecs[9];
    logic [95:0] addr_a;
    logic [95:0] addr_b;
    int rr_order[4];
    logic [31:0] rr_addr[3];
    logic [31:0] rr_data[3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        addr_a = {32'h808, 32'h804, 32'h400};
        addr_b = {32'h808, 32'h800, 32'h400};
        rr_addr = '{32'h400, 32'h800, 32'h808};
        rr_data = '{32'h00000801, 32'h1000000F, 32'h12000003};

        vecs[0] = '{3'b010, addr_a, 1, 32'h804, 32'h1100000F, 0};
        vecs[1] = '{3'b111, addr_b, 2, 32'h808, 32'h12000003, 1};
        vecs[2] = '{3'b111, addr_b, 0, 32'h400, 32'h00000801, 0};
        vecs[3] = '{3'b111, addr_b, 1, 32'h800, 32'h1000000F, 2};
        vecs[4] = '{3'b101, addr_b, 2, 32'h808, 32'hA5A50002, 0};
        vecs[5] = '{3'b011, addr_b, 0, 32'h400, 32'h00000003, 0};
        vecs[6] = '{3'b100, addr_b, 2, 32'h808, 32'hDEADBEEF, 1};
        vecs[7] = '{3'b110, addr_b, 1, 32'h800, 32'h0BADF00D, 0};
        vecs[8] = '{3'b001, addr_b, 0, 32'h400, 32'h12345678, 0};

        rst_n = 1'b0;
        bus.req_valid_i      = 3'b111;
        bus.req_addr_i       = addr_b;
        bus.resp_ready_i     = 3'b111;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_data_i       = 32'hFFFFFFFF;
        set_lock(3'b000);
        #12;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data_o), 64'd0);
        chk("rst_grant_id", 64'(bus.grant_id_o), 64'd0);
        bus.req_valid_i = 3'b000;
        bus.mem_data_i  = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request, then rotating patterns including wrap-around.
        for (int i = 0; i < 9; i++)
            do_txn(vecs[i].valid, vecs[i].addrs, vecs[i].exp_g, vecs[i].exp_addr,
                   vecs[i].data, vecs[i].lat);

        // Response back-pressure on requester 1 (rr_ptr is 1 here).
        bus.req_valid_i = 3'b011;
        #1;
        chk("bp_req_ready", 64'(bus.req_ready_o), 64'b010);
        @(posedge clk); #1;
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready_i  = 1'b0;
        bus.req_valid_i      = 3'b101;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_data_i       = 32'h5555AAAA;
        bus.resp_ready_i     = 3'b101;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_busy", 64'(bus.busy_o), 64'd1);
            chk("bp_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
            chk("bp_resp_valid", 64'(bus.resp_valid_o), 64'b010);
            chk("bp_resp_data", 64'(bus.resp_data_o), 64'h5555AAAA);
            chk("bp_no_grant", 64'(bus.req_ready_o), 64'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready_i = 3'b111;
        #1;
        chk("bp_release_ready", 64'(bus.mem_resp_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_data_i       = '0;
        chk("bp_done_busy", 64'(bus.busy_o), 64'd0);
        chk("bp_next_grant", 64'(bus.req_ready_o), 64'b100);

        // Requester 2 is granted, then reset lands mid WAIT_RESP.
        @(posedge clk); #1;
        chk("abort_grant", 64'(bus.grant_id_o), 64'd2);
        chk("abort_addr", 64'(bus.mem_addr_o), 64'h808);
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_data_i       = 32'hCAFE0001;
        bus.resp_ready_i     = 3'b011;
        #1;
        chk("abort_pre_resp_valid", 64'(bus.resp_valid_o), 64'b100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("abort_resp_data", 64'(bus.resp_data_o), 64'd0);
        chk("abort_mem_resp_ready", 64'(bus.mem_resp_ready_o), 64'd0);
        chk("abort_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("abort_grant_id", 64'(bus.grant_id_o), 64'd0);
        chk("abort_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_data_i       = '0;
        bus.req_valid_i      = 3'b000;
        bus.resp_ready_i     = 3'b111;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All three requesting from a fresh rr_ptr of 0: order 0,1,2,0.
        rr_order = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++)
            do_txn(3'b111, addr_b, rr_order[i], rr_addr[rr_order[i]], rr_data[rr_order[i]], 0);

        // Lock scenario: requester 0 reads 0x400 then 0x800, requester 1 waits.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_lock(3'b001);
        do_txn(3'b011, {32'h0, 32'h900, 32'h400}, 0, 32'h400, 32'h00000011, 0);
        set_lock(3'b000);
`ifdef MEM_PORT_ARBITER_LOCK_EN
        do_txn(3'b011, {32'h0, 32'h900, 32'h800}, 0, 32'h800, 32'h00000022, 0);
        do_txn(3'b011, {32'h0, 32'h900, 32'h800}, 1, 32'h900, 32'h00000033, 0);
`else
        do_txn(3'b011, {32'h0, 32'h900, 32'h800}, 1, 32'h900, 32'h00000022, 0);
        do_txn(3'b011, {32'h0, 32'h900, 32'h800}, 0, 32'h800, 32'h00000033, 0);
`endif
        bus.req_valid_i = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported page-table/data memory among N requesters (TLB page-table walker, instruction fetch, data port).
- Round-robin arbitration with exactly one outstanding memory transaction at a time.
- Latches the winner's address, drives the memory request handshake, and steers the memory response back to the granted requester.
- Sits between the requester ports and the memory's request/response handshake interface.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, response data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k uses slice [k*ADDR_W +: ADDR_W].
- resp_valid_o  out  NUM_REQ  per-requester response valid (one-hot or zero).
- resp_ready_i  in  NUM_REQ  per-requester response ready.
- resp_data_o  out  DATA_W  response data, broadcast; qualified by resp_valid_o.
- grant_id_o  out  clog2(NUM_REQ)  index of current/last grant.
- busy_o  out  1  high when state is not IDLE.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory request ready.
- mem_addr_o  out  ADDR_W  latched address to memory.
- mem_resp_valid_i  in  1  memory response valid.
- mem_resp_ready_o  out  1  memory response ready.
- mem_data_i  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant_id_o=0, addr_q=0.
  - All valid/ready outputs 0, mem_addr_o=0, resp_data_o=0.
  - Asserting reset in any state aborts immediately to IDLE. Arbiter and memory share the system reset, so no stray responses follow.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Winner = first k with req_valid_i[k], scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready_o[winner]=1 combinationally; all others 0.
  - On the edge: addr_q<=req_addr_i[winner], grant_id_o<=winner, go to ISSUE.
  - No valid requests: stay in IDLE, all outputs 0.
- ISSUE:
  - mem_req_valid_o=1, mem_addr_o=addr_q; held stable until mem_req_ready_i=1.
  - On valid&ready: go to WAIT_RESP.
  - req_ready_o=0 for all requesters.
- WAIT_RESP (response pass-through):
  - resp_valid_o[grant_id_o]=mem_resp_valid_i.
  - resp_data_o=mem_data_i.
  - mem_resp_ready_o=resp_ready_i[grant_id_o].
  - On mem_resp_valid_i & resp_ready_i[g]: rr_ptr<=(g+1) mod NUM_REQ (wrap at NUM_REQ-1 -> 0), go to IDLE.
  - Response ready stalls hold the state indefinitely.
- Latency:
  - Request accepted in IDLE cycle t; mem_req_valid_o high from t+1.
  - Minimum turnaround, IDLE to IDLE: 3 cycles plus memory latency.
  - A new grant is possible in the cycle immediately after a response handshake.
- Requests arriving while busy are not accepted; requesters must hold valid and address stable until req_ready_o.
- Simultaneous requests: resolved by rr_ptr only; no requester waits more than NUM_REQ-1 grants.
- req_valid_i dropping during ISSUE/WAIT_RESP has no effect; the transaction completes.

Optional Feature:
- Macro: MEM_PORT_ARBITER_LOCK_EN.
- Defined:
  - Adds port req_lock_i (in, NUM_REQ).
  - At response handshake, if req_lock_i[g]=1, rr_ptr is not advanced, and g wins the next IDLE arbitration whenever req_valid_i[g]=1. Used for atomic multi-level page walks.
  - Lock releases once req_lock_i[g]=0 at a handshake.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package mem_port_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT_RESP=2'd2);
  - ADDR_W/DATA_W defaults;
  - function ptr_wrap(idx, n).
- One sub-module: rr_picker (combinational). Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded index. Instantiated once in IDLE arbitration.

Test Plan:
- Single request: req_valid_i=3'b010, addr 0x804, memory returns 0x1100000F.
  - Expected: req_ready_o=3'b010 same cycle; mem_addr_o=0x804 next cycle; resp_valid_o=3'b010 with data 0x1100000F; rr_ptr=2.
- All three requesting continuously from reset, addresses 0x400/0x800/0x808.
  - Expected: grant order 0,1,2,0; each receives its own data (0x00000801, 0x1000000F, 0x12000003).
- Response back-pressure: resp_ready_i[g]=0 for 5 cycles.
  - Expected: state held in WAIT_RESP, mem_resp_ready_o=0, resp_valid_o stable, no new grant; completes on the ready cycle.
- Async reset asserted mid-WAIT_RESP.
  - Expected: all outputs 0 immediately without a clock edge; after release, a new request to 0x400 is served normally with rr_ptr=0.
- Lock feature on: requester 0 holds lock across two reads (0x400 then 0x800) while requester 1 is valid.
  - Expected: grants 0,0, then 1.
- Lock feature off: same stimulus.
  - Expected: grants 0,1,0.
